// File: rtl/reward_timer.sv
// rtl/reward_timer.sv - reward duration timer driven by the divider's clk_2Hz wave
// Edge-detects tick_in into tick_pulse and runs an IDLE/ACTIVE/WARN countdown that drives reward_faster.
module reward_timer #(
    parameter int DURATION_TICKS = 20,
    parameter int WARN_TICKS     = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             reward_grant,
    input  logic             reward_cancel,
    output logic             tick_pulse,
    output logic             reward_faster,
    output logic             reward_warn,
    output logic [CNT_W-1:0] ticks_left,
    output logic             reward_expired
);

    localparam logic [CNT_W-1:0] DUR_L  = CNT_W'(DURATION_TICKS);
    localparam logic [CNT_W-1:0] WARN_L = CNT_W'(WARN_TICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_WARN   = 2'd2
    } state_t;

    state_t           state;
    logic             tick_d;
    logic [CNT_W-1:0] ticks_dec;

    assign ticks_dec = ticks_left - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            // Starting high suppresses a false edge when tick_in is already high at release.
            tick_d         <= 1'b1;
            tick_pulse     <= 1'b0;
            reward_faster  <= 1'b0;
            reward_warn    <= 1'b0;
            ticks_left     <= '0;
            reward_expired <= 1'b0;
        end else begin
            tick_d         <= tick_in;
            tick_pulse     <= tick_in & ~tick_d;
            reward_expired <= 1'b0;

            if (reward_cancel) begin
                state         <= S_IDLE;
                reward_faster <= 1'b0;
                reward_warn   <= 1'b0;
                ticks_left    <= '0;
            end else if (reward_grant) begin
                state         <= S_ACTIVE;
                reward_faster <= 1'b1;
                reward_warn   <= 1'b0;
                ticks_left    <= DUR_L;
            end else if (tick_pulse) begin
                case (state)
                    S_ACTIVE, S_WARN: begin
                        ticks_left <= ticks_dec;
                        if (ticks_dec == '0) begin
                            state          <= S_IDLE;
                            reward_faster  <= 1'b0;
                            reward_warn    <= 1'b0;
                            reward_expired <= 1'b1;
                        end else if (ticks_dec <= WARN_L) begin
                            state       <= S_WARN;
                            reward_warn <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reward_timer.sv
// tb/tb_reward_timer.sv - randomized scoreboard bench for reward_timer
module tb_reward_timer;
    localparam int DUR  = 20;
    localparam int WARN = 4;
    localparam int W    = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick_in = 1'b1;
    logic         reward_grant = 1'b0;
    logic         reward_cancel = 1'b0;
    logic         tick_pulse;
    logic         reward_faster;
    logic         reward_warn;
    logic [W-1:0] ticks_left;
    logic         reward_expired;

    int errors = 0;
    int checks = 0;

    // Expected {tick_pulse, reward_faster, reward_warn, ticks_left, reward_expired}
    logic [W+3:0] exp_q[$];

    // Reference model: a reward is "on" with some ticks remaining; warning is just "few ticks remain".
    bit m_on   = 1'b0;
    int m_left = 0;
    bit m_tp   = 1'b0;
    bit m_prev = 1'b1;
    bit m_exp  = 1'b0;

    reward_timer #(.DURATION_TICKS(DUR), .WARN_TICKS(WARN), .CNT_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_in        (tick_in),
        .reward_grant   (reward_grant),
        .reward_cancel  (reward_cancel),
        .tick_pulse     (tick_pulse),
        .reward_faster  (reward_faster),
        .reward_warn    (reward_warn),
        .ticks_left     (ticks_left),
        .reward_expired (reward_expired)
    );

    initial forever #5 clk = ~clk;

    task automatic cycle(input bit r, input bit g, input bit c, input bit t);
        @(negedge clk);
        rst           = r;
        reward_grant  = g;
        reward_cancel = c;
        tick_in       = t;
        if (r) begin
            m_on   = 1'b0;
            m_left = 0;
            m_tp   = 1'b0;
            m_prev = 1'b1;
            m_exp  = 1'b0;
        end else begin
            m_exp = 1'b0;
            if (c) begin
                m_on   = 1'b0;
                m_left = 0;
            end else if (g) begin
                m_on   = 1'b1;
                m_left = DUR;
            end else if (m_tp && m_on) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_on  = 1'b0;
                    m_exp = 1'b1;
                end
            end
            m_tp   = t && !m_prev;
            m_prev = t;
        end
        exp_q.push_back({m_tp, m_on, (m_on && m_left <= WARN), W'(m_left), m_exp});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin : monitor
        logic [W+3:0] e;
        logic [W+3:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {tick_pulse, reward_faster, reward_warn, ticks_left, reward_expired};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got tp=%b faster=%b warn=%b left=%0d expired=%b, want tp=%b faster=%b warn=%b left=%0d expired=%b",
                             $time, got[W+3], got[W+2], got[W+1], got[W:1], got[0],
                             e[W+3], e[W+2], e[W+1], e[W:1], e[0]);
                end
            end
        end
    end

    initial begin : stimulus
        bit r, g, c, t;
        // T1: reset with tick_in held high, then one real edge
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        // T2: full reward to natural expiry, plus extra ticks in IDLE
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick(DUR + 2);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        // T3: regrant mid-reward
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick(10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick(3);
        // T4: grant+cancel together in WARN at ticks_left=2
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick(DUR - 2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        tick(2);
        // T5: grant coincident with tick_pulse at ticks_left=5
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick(DUR - 5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick(2);
        // T6: reset mid-reward at ticks_left=7
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick(DUR - 7);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tick(5);
        // Randomized traffic
        t = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 599) == 0);
            g = ($urandom_range(0, 69) == 0);
            c = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 2) == 0) t = !t;
            cycle(r, g, c, t);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
